h5_butterfly_add: RTL and testbench



---
 rtl/h5_butterfly_add.sv | 110 +++++++++++
 tb/tb_h5_butterfly_add.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/h5_butterfly_add.sv
// Sign-magnitude radix-2 butterfly (Y0/Y1 from X0+-X1, Y2/Y3 from X2+-X3), two-stage valid/ready pipeline.
// Define H_ADD_SAT_EN to clamp overflowing lanes to +-2047; otherwise they wrap modulo 2048.
module h5_butterfly_add (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [11:0] X0,
    input  logic [11:0] X1,
    input  logic [11:0] X2,
    input  logic [11:0] X3,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [11:0] Y0,
    output logic [11:0] Y1,
    output logic [11:0] Y2,
    output logic [11:0] Y3,
    output logic [3:0]  OVF,
    input  logic        CLR_SAT,
    output logic [7:0]  SAT_CNT
);

    logic               en;
    logic [11:0]        x_lane [4];
    logic signed [12:0] dec_val [4];
    logic signed [12:0] sum_next [4];
    logic signed [12:0] sum_reg [4];
    logic               s1_valid_reg;
    logic [12:0]        abs_val [4];
    logic [10:0]        mag_next [4];
    logic [11:0]        y_next [4];
    logic [3:0]         ovf_next;
    logic [11:0]        y_reg [4];
    logic [3:0]         ovf_reg;
    logic               out_valid_reg;
    logic [7:0]         sat_cnt_reg;

    // Whole pipeline advances together; a full stage 2 blocks everything upstream.
    assign en       = !out_valid_reg || OUT_READY;
    assign IN_READY = en;

    assign x_lane[0] = X0;
    assign x_lane[1] = X1;
    assign x_lane[2] = X2;
    assign x_lane[3] = X3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Negative zero decodes to 0 naturally since -0 == 0.
            assign dec_val[gi] = x_lane[gi][11] ? -$signed({2'b00, x_lane[gi][10:0]})
                                                :  $signed({2'b00, x_lane[gi][10:0]});

            assign abs_val[gi]  = sum_reg[gi][12] ? 13'(-sum_reg[gi]) : 13'(sum_reg[gi]);
            assign ovf_next[gi] = |abs_val[gi][12:11];
`ifdef H_ADD_SAT_EN
            assign mag_next[gi] = ovf_next[gi] ? 11'h7FF : abs_val[gi][10:0];
`else
            assign mag_next[gi] = abs_val[gi][10:0];
`endif
            // Sign only for a nonzero negative magnitude, so -0 is never emitted.
            assign y_next[gi] = {sum_reg[gi][12] && (mag_next[gi] != 11'd0), mag_next[gi]};
        end

        for (gi = 0; gi < 2; gi++) begin : g_pair
            assign sum_next[2*gi]   = dec_val[2*gi] + dec_val[2*gi+1];
            assign sum_next[2*gi+1] = dec_val[2*gi] - dec_val[2*gi+1];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 4'd0;
            sat_cnt_reg   <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                sum_reg[i] <= '0;
                y_reg[i]   <= '0;
            end
        end else begin
            if (en) begin
                s1_valid_reg  <= IN_VALID;
                out_valid_reg <= s1_valid_reg;
                if (IN_VALID) begin
                    for (int i = 0; i < 4; i++) sum_reg[i] <= sum_next[i];
                end
                // Bubbles leave the visible result untouched.
                if (s1_valid_reg) begin
                    for (int i = 0; i < 4; i++) y_reg[i] <= y_next[i];
                    ovf_reg <= ovf_next;
                end
            end
            if (CLR_SAT) begin
                sat_cnt_reg <= 8'd0;
            end else if (en && s1_valid_reg && (|ovf_next) && (sat_cnt_reg != 8'hFF)) begin
                sat_cnt_reg <= sat_cnt_reg + 8'd1;
            end
        end
    end

    assign OUT_VALID = out_valid_reg;
    assign Y0        = y_reg[0];
    assign Y1        = y_reg[1];
    assign Y2        = y_reg[2];
    assign Y3        = y_reg[3];
    assign OVF       = ovf_reg;
    assign SAT_CNT   = sat_cnt_reg;

endmodule

// File: tb/tb_h5_butterfly_add.sv
// Self-checking bench for h5_butterfly_add: arithmetic model + scoreboard queue, plus directed literal checks.
// Honours H_ADD_SAT_EN to pick saturating or wrapping expectations.
module tb_h5_butterfly_add;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [11:0] X0, X1, X2, X3;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [11:0] Y0, Y1, Y2, Y3;
    logic [3:0]  OVF;
    logic        CLR_SAT;
    logic [7:0]  SAT_CNT;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    logic [51:0] exp_q [$];

    always #5 CLK = ~CLK;

    h5_butterfly_add dut (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .X0(X0), .X1(X1), .X2(X2), .X3(X3),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .OVF(OVF),
        .CLR_SAT(CLR_SAT), .SAT_CNT(SAT_CNT)
    );

    function automatic int dec(input logic [11:0] v);
        int m;
        m = int'(v[10:0]);
        return v[11] ? -m : m;
    endfunction

    // Returns {ovf, sign, magnitude} for an exact integer result.
    function automatic logic [12:0] enc(input int r);
        int   a, m;
        logic o, s;
        a = (r < 0) ? -r : r;
        o = (a > 2047);
`ifdef H_ADD_SAT_EN
        m = o ? 2047 : a;
`else
        m = a % 2048;
`endif
        s = (r < 0) && (m != 0);
        return {o, s, 11'(m)};
    endfunction

    function automatic logic [51:0] model(input logic [11:0] a, b, c, d);
        int          r [4];
        logic [12:0] e [4];
        r[0] = dec(a) + dec(b);
        r[1] = dec(a) - dec(b);
        r[2] = dec(c) + dec(d);
        r[3] = dec(c) - dec(d);
        for (int i = 0; i < 4; i++) e[i] = enc(r[i]);
        return {e[0][11:0], e[1][11:0], e[2][11:0], e[3][11:0],
                e[3][12], e[2][12], e[1][12], e[0][12]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Compare process: scores every delivered beat, records every accepted beat.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            exp_q.delete();
        end else begin
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", {Y0, Y1, Y2, Y3, OVF});
                end else begin
                    check("beat", {Y0, Y1, Y2, Y3, OVF}, exp_q.pop_front());
                    delivered++;
                    $display("beat %0d: Y=%03h %03h %03h %03h OVF=%b SAT_CNT=%0d",
                             delivered, Y0, Y1, Y2, Y3, OVF, SAT_CNT);
                end
            end
            if (IN_VALID && IN_READY) exp_q.push_back(model(X0, X1, X2, X3));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic present(input logic [11:0] a, b, c, d);
        X0 = a; X1 = b; X2 = c; X3 = d;
        IN_VALID = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge CLK);
        while (!IN_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) check("accept_timeout", 64'(IN_READY), 64'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic send(input logic [11:0] a, b, c, d);
        present(a, b, c, d);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || OUT_VALID) && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    logic [11:0] vec [5][4] = '{
        '{12'hFFF, 12'hFFF, 12'h000, 12'hFFF},
        '{12'h400, 12'h400, 12'hC00, 12'h400},
        '{12'h123, 12'h456, 12'hFFF, 12'h001},
        '{12'h800, 12'h7FF, 12'h001, 12'hFFF},
        '{12'h3E8, 12'hBE8, 12'h7FE, 12'h002}
    };

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        RESET_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; CLR_SAT = 1'b0;
        X0 = '0; X1 = '0; X2 = '0; X3 = '0;
        #2;
        check("rst_in_ready", 64'(IN_READY), 64'd1);
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_y_ovf", {Y0, Y1, Y2, Y3, OVF}, 64'd0);
        check("rst_sat_cnt", 64'(SAT_CNT), 64'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        tick(1);

        // Basic arithmetic with latency pinned
        send(12'h064, 12'h81E, 12'h005, 12'h805);
        check("basic_early", 64'(OUT_VALID), 64'd0);
        tick(1);
        check("basic_valid", 64'(OUT_VALID), 64'd1);
        check("basic_y", {Y0, Y1, Y2, Y3, OVF}, {12'h046, 12'h082, 12'h000, 12'h00A, 4'b0000});
        drain();

        // Single overflow
        send(12'h000, 12'h000, 12'h7D0, 12'h064);
        tick(1);
`ifdef H_ADD_SAT_EN
        check("ovf_y2", 64'(Y2), 64'h7FF);
`else
        check("ovf_y2", 64'(Y2), 64'h034);
`endif
        check("ovf_y3", 64'(Y3), 64'h76C);
        check("ovf_flags", 64'(OVF), 64'b0100);
        check("ovf_sat1", 64'(SAT_CNT), 64'd1);
        drain();

        for (int i = 0; i < 300; i++) send(12'h000, 12'h000, 12'h7D0, 12'h064);
        drain();
        check("sat_255", 64'(SAT_CNT), 64'd255);

        // Clear coinciding with an overflowing stage-2 load
        present(12'h000, 12'h000, 12'h7D0, 12'h064);
        wait_accept();
        CLR_SAT = 1'b1;
        tick(1);
        CLR_SAT = 1'b0;
        check("clr_priority", 64'(SAT_CNT), 64'd0);
        check("clr_beat_ovf", {63'd0, OUT_VALID, 60'd0, OVF}, {63'd0, 1'b1, 60'd0, 4'b0100});
        drain();

        // Negative zero everywhere
        send(12'h800, 12'h000, 12'h800, 12'h800);
        tick(1);
        check("negzero_valid", 64'(OUT_VALID), 64'd1);
        check("negzero_y", {Y0, Y1, Y2, Y3, OVF}, 64'd0);
        drain();

        // Extreme magnitudes pinned by hand
        send(12'h7FF, 12'h7FF, 12'hFFF, 12'h7FF);
        tick(1);
`ifdef H_ADD_SAT_EN
        check("extreme_y", {Y0, Y1, Y2, Y3, OVF}, {12'h7FF, 12'h000, 12'h000, 12'hFFF, 4'b1001});
`else
        check("extreme_y", {Y0, Y1, Y2, Y3, OVF}, {12'h7FE, 12'h000, 12'h000, 12'hFFE, 4'b1001});
`endif
        drain();

        // Back-to-back vector table, checked by the model
        for (int i = 0; i < 5; i++) send(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
        drain();

        // Back-pressure: A and B fill the pipe, C must wait
        d0 = delivered;
        OUT_READY = 1'b0;
        send(12'h010, 12'h005, 12'h020, 12'h803);
        send(12'h111, 12'h222, 12'h333, 12'h444);
        present(12'h7FF, 12'h001, 12'h800, 12'h000);
        tick(3);
        check("bp_in_ready", 64'(IN_READY), 64'd0);
        check("bp_out_valid", 64'(OUT_VALID), 64'd1);
        check("bp_hold_a", {Y0, Y1, Y2, Y3, OVF}, {12'h015, 12'h00B, 12'h01D, 12'h023, 4'b0000});
        OUT_READY = 1'b1;
        wait_accept();
        drain();
        check("bp_delivered", 64'(delivered - d0), 64'd3);

        // Reset with two beats in flight
        OUT_READY = 1'b0;
        send(12'h7D0, 12'h064, 12'h000, 12'h000);
        send(12'h7D0, 12'h064, 12'h000, 12'h000);
        #3;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("mid_rst_y_ovf", {Y0, Y1, Y2, Y3, OVF}, 64'd0);
        check("mid_rst_sat", 64'(SAT_CNT), 64'd0);
        check("mid_rst_in_ready", 64'(IN_READY), 64'd1);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        OUT_READY = 1'b1;
        tick(1);
        check("post_rst_idle", 64'(OUT_VALID), 64'd0);
        send(12'h064, 12'h81E, 12'h005, 12'h805);
        check("post_rst_early", 64'(OUT_VALID), 64'd0);
        tick(1);
        check("post_rst_valid", 64'(OUT_VALID), 64'd1);
        check("post_rst_y", {Y0, Y1, Y2, Y3, OVF}, {12'h046, 12'h082, 12'h000, 12'h00A, 4'b0000});
        drain();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
